pipeline_hazard_controller: RTL

- Sequences the 5-stage pipeline: PC, IF_ID, CU_mux, ID_EX, EX_MEM.
- Generates the load enables for the PC and pipeline registers, and the CU_mux NOP select S.
- Generates the IF_ID flush and the operand forwarding selects for EX.
- Arbitrates load-use stalls, taken-branch flushes and data-memory wait states through a small FSM, and keeps saturating stall/flush counters.

---
 rtl/pipeline_hazard_controller_if.sv | 46 ++++
 rtl/pipeline_hazard_controller.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-control bundle between the 5-stage datapath and its hazard controller.
// master = pipeline datapath (supplies register/stage info, consumes controls)
// slave  = pipeline_hazard_controller
// CNT_W here must match the controller's CNT_W.
interface pipeline_hazard_controller_if #(
  parameter int CNT_W = 16
);
  // ID-stage sources and their use flags
  logic [3:0]       id_rn, id_rm, id_rd;
  logic             id_use_rn, id_use_rm, id_use_rd;
  // Downstream destinations
  logic [3:0]       ex_rd;
  logic             ex_rf_enable, ex_load_instr;
  logic [3:0]       mem_rd;
  logic             mem_rf_enable;
  logic [3:0]       wb_rd;
  logic             wb_rf_enable;
  // Control-flow and memory status
  logic             branch_taken;
  logic             mem_busy;
  // Controls back to the datapath
  logic             pc_LE, ifid_LE, idex_LE, exmem_LE;
  logic             S;
  logic             ifid_flush;
  logic [1:0]       fwd_a, fwd_b, fwd_c;
  // Status
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count, flush_count;
  logic             mem_timeout;

  modport master (
    output id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
    output ex_rd, ex_rf_enable, ex_load_instr, mem_rd, mem_rf_enable,
    output wb_rd, wb_rf_enable, branch_taken, mem_busy,
    input  pc_LE, ifid_LE, idex_LE, exmem_LE, S, ifid_flush,
    input  fwd_a, fwd_b, fwd_c, state, stall_count, flush_count, mem_timeout
  );

  modport slave (
    input  id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
    input  ex_rd, ex_rf_enable, ex_load_instr, mem_rd, mem_rf_enable,
    input  wb_rd, wb_rf_enable, branch_taken, mem_busy,
    output pc_LE, ifid_LE, idex_LE, exmem_LE, S, ifid_flush,
    output fwd_a, fwd_b, fwd_c, state, stall_count, flush_count, mem_timeout
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for the PC / IF_ID / CU_mux / ID_EX / EX_MEM pipeline.
// Produces register load enables, the CU_mux bubble select, the IF_ID flush
// and EX operand forwarding selects; arbitrates load-use stalls, taken-branch
// flushes and data-memory wait states; keeps saturating stall/flush counters.
module pipeline_hazard_controller #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 16
) (
  input logic                         clk,
  input logic                         R,
  pipeline_hazard_controller_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LD_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  localparam int             WCW        = $clog2(WAIT_MAX + 1);
  localparam logic [WCW-1:0] WAIT_MAX_C = WCW'(WAIT_MAX);

  // Forward select for one source: EX > MEM > WB; R15 and unused sources never forward.
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] src,     input logic use_src,
    input logic [3:0] ex_rd,   input logic ex_en,
    input logic [3:0] mem_rd,  input logic mem_en,
    input logic [3:0] wb_rd,   input logic wb_en
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (use_src && src != 4'hF) begin
      if (ex_en && ex_rd == src)        sel = 2'b01;
      else if (mem_en && mem_rd == src) sel = 2'b10;
      else if (wb_en && wb_rd == src)   sel = 2'b11;
    end
    return sel;
  endfunction

  state_t           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic [1:0] sel_a, sel_b, sel_c;
  logic       load_hazard;
  logic       pc_le, ifid_le, idex_le, exmem_le, bubble, flush;

  // Forwarding selects and load-use detection (independent of FSM state).
  always_comb begin
    sel_a = fwd_sel(bus.id_rn, bus.id_use_rn, bus.ex_rd, bus.ex_rf_enable,
                    bus.mem_rd, bus.mem_rf_enable, bus.wb_rd, bus.wb_rf_enable);
    sel_b = fwd_sel(bus.id_rm, bus.id_use_rm, bus.ex_rd, bus.ex_rf_enable,
                    bus.mem_rd, bus.mem_rf_enable, bus.wb_rd, bus.wb_rf_enable);
    sel_c = fwd_sel(bus.id_rd, bus.id_use_rd, bus.ex_rd, bus.ex_rf_enable,
                    bus.mem_rd, bus.mem_rf_enable, bus.wb_rd, bus.wb_rf_enable);
    load_hazard = bus.ex_load_instr & bus.ex_rf_enable &
                  ((bus.id_use_rn & (bus.id_rn != 4'hF) & (bus.id_rn == bus.ex_rd)) |
                   (bus.id_use_rm & (bus.id_rm != 4'hF) & (bus.id_rm == bus.ex_rd)) |
                   (bus.id_use_rd & (bus.id_rd != 4'hF) & (bus.id_rd == bus.ex_rd)));
  end

  // FSM next state, pipeline controls, wait/timeout tracking and counter updates.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    pc_le         = 1'b1;
    ifid_le       = 1'b1;
    idex_le       = 1'b1;
    exmem_le      = 1'b1;
    bubble        = 1'b0;
    flush         = 1'b0;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;

    case (state_q)
      RUN, LD_STALL: begin
        if (bus.mem_busy) begin
          {pc_le, ifid_le, idex_le, exmem_le} = 4'b0000;
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end else if (load_hazard && state_q == RUN) begin
          // The load moves on into MEM while ID holds and a bubble enters EX.
          pc_le   = 1'b0;
          ifid_le = 1'b0;
          bubble  = 1'b1;
          state_d = LD_STALL;
        end else begin
          flush   = bus.branch_taken;
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        // Whole pipeline frozen, including the exit cycle; a pending branch
        // stays in ID and is re-evaluated once back in RUN.
        {pc_le, ifid_le, idex_le, exmem_le} = 4'b0000;
        if (wait_cnt_q != WAIT_MAX_C) wait_cnt_d = wait_cnt_q + WCW'(1);
        if (wait_cnt_d == WAIT_MAX_C) mem_timeout_d = 1'b1;
        state_d = bus.mem_busy ? MEM_WAIT : RUN;
      end
      default: state_d = RUN;
    endcase

    stall_count_d = stall_count_q;
    if (!pc_le && stall_count_q != '1) stall_count_d = stall_count_q + CNT_W'(1);
    flush_count_d = flush_count_q;
    if (flush && flush_count_q != '1) flush_count_d = flush_count_q + CNT_W'(1);
  end

  // State, wait counter, sticky timeout and statistics registers.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  // While reset is low the controls are forced to a safe frozen bubble.
  assign bus.pc_LE       = R & pc_le;
  assign bus.ifid_LE     = R & ifid_le;
  assign bus.idex_LE     = R & idex_le;
  assign bus.exmem_LE    = R & exmem_le;
  assign bus.S           = ~R | bubble;
  assign bus.ifid_flush  = R & flush;
  assign bus.fwd_a       = R ? sel_a : 2'b00;
  assign bus.fwd_b       = R ? sel_b : 2'b00;
  assign bus.fwd_c       = R ? sel_c : 2'b00;
  assign bus.state       = state_q;
  assign bus.stall_count = stall_count_q;
  assign bus.flush_count = flush_count_q;
  assign bus.mem_timeout = mem_timeout_q;

endmodule
